// File: rtl/culsans_pkg.sv
// -----------------------------------------------------------------------------
// culsans_pkg
//
// Shared definitions for the Culsans simulation-exit monitor:
//   - exitAddr         : the address whose write ends a simulation run
//   - AXI channel and bundle structs (req_slv_t / resp_slv_t) used as the
//     default monitored request/response types
//   - exit_mon_state_t : state encoding of the exit monitor FSM
//
// The exit monitor's optional watchdog is controlled by the
// CULSANS_EXIT_TIMEOUT_EN macro (see culsans_exit_monitor.sv).
// -----------------------------------------------------------------------------
package culsans_pkg;

  // ---------------------------------------------------------------------------
  // Bus geometry
  // ---------------------------------------------------------------------------
  localparam int unsigned AxiIdWidth   = 4;
  localparam int unsigned AxiAddrWidth = 64;
  localparam int unsigned AxiDataWidth = 64;
  localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;

  // Writing here terminates the simulation; wdata carries the exit status.
  localparam logic [63:0] exitAddr = 64'h0000_0000_0000_1000;

  // AXI response codes
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  // ---------------------------------------------------------------------------
  // Channel payloads
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } aw_chan_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [AxiStrbWidth-1:0] strb;
    logic                    last;
  } w_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0] id;
    logic [1:0]            resp;
  } b_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiAddrWidth-1:0] addr;
    logic [7:0]              len;
    logic [2:0]              size;
    logic [1:0]              burst;
  } ar_chan_t;

  typedef struct packed {
    logic [AxiIdWidth-1:0]   id;
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
    logic                    last;
  } r_chan_t;

  // ---------------------------------------------------------------------------
  // Bundles (master -> slave request, slave -> master response)
  // ---------------------------------------------------------------------------
  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_slv_t;

  typedef struct packed {
    logic     aw_ready;
    logic     ar_ready;
    logic     w_ready;
    logic     b_valid;
    b_chan_t  b;
    logic     r_valid;
    r_chan_t  r;
  } resp_slv_t;

  // ---------------------------------------------------------------------------
  // Exit monitor FSM states
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_W = 2'd1,
    WAIT_B = 2'd2,
    DONE   = 2'd3
  } exit_mon_state_t;

endpackage

// File: rtl/culsans_exit_monitor.sv
// -----------------------------------------------------------------------------
// culsans_exit_monitor
//
// Passive AXI write-path monitor that detects the simulation-exit write. It
// tracks the first AW to ExitAddr, finds that burst's first W beat (skipping
// W bursts that belong to earlier AWs), waits for the matching B and then
// reports the exit status. Read channels are ignored.
//
// Optional feature: define CULSANS_EXIT_TIMEOUT_EN to enable a 32-bit
// watchdog that raises timeout_o after TimeoutCycles cycles without DONE.
// Without the macro, timeout_o is tied low and no counter exists.
//
// Ports
//   clk_i          in   clock (single domain)
//   rst_i          in   synchronous active-high reset
//   req_i          in   monitored AXI request bundle (never driven)
//   resp_i         in   monitored AXI response bundle
//   done_o         out  sticky: exit write completed (B received)
//   exit_code_o    out  {1'b0, captured wdata[31:1]}, valid with done_o
//   pass_o         out  done_o && exit_code_o == 0
//   resp_err_o     out  sticky: exit B response was not OKAY
//   protocol_err_o out  sticky: pending-burst over/underflow or exit len != 0
//   timeout_o      out  sticky: watchdog expired
// -----------------------------------------------------------------------------
module culsans_exit_monitor
  import culsans_pkg::*;
#(
  parameter logic [63:0] ExitAddr      = culsans_pkg::exitAddr,
  parameter int unsigned MaxPending    = 8,
  parameter logic [31:0] TimeoutCycles = 32'd10_000_000,
  parameter type         req_t         = culsans_pkg::req_slv_t,
  parameter type         resp_t        = culsans_pkg::resp_slv_t
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  req_t        req_i,
  input  resp_t       resp_i,
  output logic        done_o,
  output logic [31:0] exit_code_o,
  output logic        pass_o,
  output logic        resp_err_o,
  output logic        protocol_err_o,
  output logic        timeout_o
);

  localparam int unsigned PendW = $clog2(MaxPending + 1);

  // ---------------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------------
  logic w_aw_hs;
  logic w_w_hs;
  logic w_wlast_hs;
  logic w_b_hs;
  logic w_exit_aw;

  assign w_aw_hs    = req_i.aw_valid & resp_i.aw_ready;
  assign w_w_hs     = req_i.w_valid & resp_i.w_ready;
  assign w_wlast_hs = w_w_hs & req_i.w.last;
  assign w_b_hs     = resp_i.b_valid & req_i.b_ready;
  assign w_exit_aw  = w_aw_hs & (req_i.aw.addr == ExitAddr);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  exit_mon_state_t             r_state;
  exit_mon_state_t             w_state_next;
  logic [PendW-1:0]            r_pend;
  logic [PendW-1:0]            w_pend_next;
  logic                        w_pend_err;
  logic [PendW-1:0]            r_skip;
  logic [PendW-1:0]            w_skip_next;
  logic [AxiIdWidth-1:0]       r_id;
  logic [31:0]                 r_data;
  logic                        r_done;
  logic [31:0]                 r_exit_code;
  logic                        r_resp_err;
  logic                        r_protocol_err;

  // FSM-derived control strobes
  logic w_id_capture;
  logic w_data_capture;
  logic w_len_err;
  logic w_done_set;

  // ---------------------------------------------------------------------------
  // Pending-burst counter: AWs accepted whose W-last has not been seen yet.
  // A simultaneous AW and W-last cancel out, so no bound check applies.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal assigned in this block gets a default first; a path
    // that leaves one unassigned would infer a latch.
    w_pend_next = r_pend;
    w_pend_err  = 1'b0;
    if (w_aw_hs && !w_wlast_hs) begin
      if (r_pend == PendW'(MaxPending)) begin
        w_pend_err = 1'b1;               // saturate
      end else begin
        w_pend_next = r_pend + PendW'(1);
      end
    end else if (w_wlast_hs && !w_aw_hs) begin
      if (r_pend == '0) begin
        w_pend_err = 1'b1;               // hold at zero
      end else begin
        w_pend_next = r_pend - PendW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state / strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_skip_next    = r_skip;
    w_id_capture   = 1'b0;
    w_data_capture = 1'b0;
    w_len_err      = 1'b0;
    w_done_set     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_exit_aw) begin
          w_state_next = WAIT_W;
          w_id_capture = 1'b1;
          w_len_err    = (req_i.aw.len != '0);
          // Bursts already pending own the next W-lasts. A W-last landing in
          // this same cycle closes one of them. Clamped at zero for the case
          // where nothing was pending.
          if (w_wlast_hs) begin
            w_skip_next = (r_pend == '0) ? '0 : r_pend - PendW'(1);
          end else begin
            w_skip_next = r_pend;
          end
        end
      end

      WAIT_W: begin
        if (w_w_hs) begin
          if (r_skip != '0) begin
            // Beat of an older burst; only its last beat retires it.
            if (req_i.w.last) begin
              w_skip_next = r_skip - PendW'(1);
            end
          end else begin
            w_data_capture = 1'b1;
            w_state_next   = WAIT_B;
          end
        end
      end

      WAIT_B: begin
        if (w_b_hs && (resp_i.b.id == r_id)) begin
          w_done_set   = 1'b1;
          w_state_next = DONE;
        end
      end

      DONE: begin
        w_state_next = DONE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath / sticky outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend         <= '0;
      r_skip         <= '0;
      r_id           <= '0;
      r_data         <= '0;
      r_done         <= 1'b0;
      r_exit_code    <= '0;
      r_resp_err     <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      r_skip <= w_skip_next;

      if (w_id_capture) begin
        r_id <= req_i.aw.id;
      end

      if (w_data_capture) begin
        r_data <= req_i.w.data[31:0];
      end

      if (w_pend_err || w_len_err) begin
        r_protocol_err <= 1'b1;
      end

      // Exit code is published together with done so it reads 0 until then.
      if (w_done_set) begin
        r_done      <= 1'b1;
        r_exit_code <= {1'b0, r_data[31:1]};
        if (resp_i.b.resp != RespOkay) begin
          r_resp_err <= 1'b1;
        end
      end
    end
  end

  assign done_o         = r_done;
  assign exit_code_o    = r_exit_code;
  assign pass_o         = r_done & (r_exit_code == '0);
  assign resp_err_o     = r_resp_err;
  assign protocol_err_o = r_protocol_err;

  // ---------------------------------------------------------------------------
  // Watchdog (optional)
  // ---------------------------------------------------------------------------
  // The monitor is passive: most bundle fields (read channels, strobes, ...)
  // are intentionally ignored and folded here.
  logic w_unused;

`ifdef CULSANS_EXIT_TIMEOUT_EN
  logic [31:0] r_wd_cnt;
  logic        r_timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else if ((r_state != DONE) && !r_timeout) begin
      r_wd_cnt <= r_wd_cnt + 32'd1;
      if ((r_wd_cnt + 32'd1) == TimeoutCycles) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
  assign w_unused  = ^{req_i, resp_i};
`else
  assign timeout_o = 1'b0;
  assign w_unused  = ^{req_i, resp_i, TimeoutCycles};
`endif

endmodule

// File: tb/tb_culsans_exit_monitor.sv
// -----------------------------------------------------------------------------
// tb_culsans_exit_monitor
//
// Directed self-checking bench for culsans_exit_monitor. Inputs change #1
// after the rising edge and outputs are checked at the same point, so each
// check observes the registers updated by the edge just taken.
// Watchdog checks follow CULSANS_EXIT_TIMEOUT_EN (TimeoutCycles = 100).
// -----------------------------------------------------------------------------
module tb_culsans_exit_monitor;
  import culsans_pkg::*;

  localparam logic [63:0] Other = 64'h0000_0000_0000_0100;

  logic        clk;
  logic        rst;
  req_slv_t    req;
  resp_slv_t   resp;
  logic        done;
  logic [31:0] exit_code;
  logic        pass;
  logic        resp_err;
  logic        protocol_err;
  logic        timeout;

  int n_checks = 0;
  int n_errors = 0;

  culsans_exit_monitor #(
    .ExitAddr      (exitAddr),
    .MaxPending    (8),
    .TimeoutCycles (32'd100),
    .req_t         (req_slv_t),
    .resp_t        (resp_slv_t)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .resp_i         (resp),
    .done_o         (done),
    .exit_code_o    (exit_code),
    .pass_o         (pass),
    .resp_err_o     (resp_err),
    .protocol_err_o (protocol_err),
    .timeout_o      (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; then drop all valids.
  task automatic cycle();
    @(posedge clk);
    #1;
    req.aw_valid  = 1'b0;
    req.w_valid   = 1'b0;
    req.ar_valid  = 1'b0;
    resp.b_valid  = 1'b0;
    resp.r_valid  = 1'b0;
  endtask

  task automatic set_aw(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
    req.aw_valid = 1'b1;
    req.aw.id    = id;
    req.aw.addr  = addr;
    req.aw.len   = len;
  endtask

  task automatic set_w(input logic [63:0] data, input logic last);
    req.w_valid = 1'b1;
    req.w.data  = data;
    req.w.last  = last;
  endtask

  task automatic set_b(input logic [3:0] id, input logic [1:0] rsp);
    resp.b_valid = 1'b1;
    resp.b.id    = id;
    resp.b.resp  = rsp;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_done"},  {31'd0, done},         32'd0);
    check({tag, "_code"},  exit_code,             32'd0);
    check({tag, "_pass"},  {31'd0, pass},         32'd0);
    check({tag, "_rerr"},  {31'd0, resp_err},     32'd0);
    check({tag, "_perr"},  {31'd0, protocol_err}, 32'd0);
    check({tag, "_tmo"},   {31'd0, timeout},      32'd0);
  endtask

  // Hard time bound so the bench always ends.
  initial begin
    #200_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst  = 1'b1;
    req  = '0;
    resp = '0;
    resp.aw_ready = 1'b1;
    resp.w_ready  = 1'b1;
    resp.ar_ready = 1'b1;
    req.b_ready   = 1'b1;
    req.r_ready   = 1'b1;

    // ---------------- Reset state ----------------
    do_reset();
    check_all_clear("rst");

    // ---------------- Basic exit, passing (read traffic ignored) ---------
    set_aw(4'd3, exitAddr, 8'd0);
    req.ar_valid = 1'b1;
    req.ar.addr  = exitAddr;
    cycle();
    set_w(64'h1, 1'b1);
    resp.r_valid = 1'b1;
    cycle();
    check("basic_done_pre", {31'd0, done}, 32'd0);
    set_b(4'd3, RespOkay);
    cycle();
    check("basic_done", {31'd0, done},         32'd1);
    check("basic_code", exit_code,             32'd0);
    check("basic_pass", {31'd0, pass},         32'd1);
    check("basic_rerr", {31'd0, resp_err},     32'd0);
    check("basic_perr", {31'd0, protocol_err}, 32'd0);
    cycle();
    check("basic_sticky", {31'd0, done}, 32'd1);

    // ---------------- Skip earlier bursts ----------------
    do_reset();
    set_aw(4'd1, Other, 8'd1);
    cycle();
    set_aw(4'd2, Other, 8'd1);
    cycle();
    set_aw(4'd3, exitAddr, 8'd0);
    cycle();
    set_w(64'hA0, 1'b0); cycle();
    set_w(64'hA1, 1'b1); cycle();
    set_w(64'hA2, 1'b0); cycle();
    set_w(64'hA3, 1'b1); cycle();
    set_w(64'hB,  1'b1); cycle();
    check("skip_done_pre", {31'd0, done}, 32'd0);
    check("skip_code_pre", exit_code,     32'd0);
    set_b(4'd3, RespOkay);
    cycle();
    check("skip_done", {31'd0, done},         32'd1);
    check("skip_code", exit_code,             32'd5);
    check("skip_pass", {31'd0, pass},         32'd0);
    check("skip_perr", {31'd0, protocol_err}, 32'd0);

    // ---------------- Foreign B ignored, error response ----------------
    do_reset();
    set_aw(4'd3, exitAddr, 8'd0); cycle();
    set_w(64'h4, 1'b1);           cycle();
    set_b(4'd2, RespOkay);        cycle();
    check("bid_other_done", {31'd0, done}, 32'd0);
    set_b(4'd3, RespSlvErr);      cycle();
    check("bid_done", {31'd0, done},     32'd1);
    check("bid_rerr", {31'd0, resp_err}, 32'd1);
    check("bid_code", exit_code,         32'd2);
    check("bid_pass", {31'd0, pass},     32'd0);

    // ---------------- Simultaneous AW and W-last ----------------
    do_reset();
    set_aw(4'd1, Other, 8'd0); cycle();
    set_aw(4'd5, exitAddr, 8'd0);
    set_w(64'h77, 1'b1);       cycle();
    set_w(64'h40, 1'b1);       cycle();
    set_b(4'd5, RespOkay);     cycle();
    check("simul_done", {31'd0, done},         32'd1);
    check("simul_code", exit_code,             32'h20);
    check("simul_perr", {31'd0, protocol_err}, 32'd0);

    // ---------------- Reset mid-transaction ----------------
    do_reset();
    set_aw(4'd3, exitAddr, 8'd0); cycle();
    set_w(64'h2, 1'b1);           cycle();
    do_reset();
    check_all_clear("midrst");
    set_b(4'd3, RespOkay);        cycle();
    check("midrst_b_done", {31'd0, done}, 32'd0);
    set_w(64'h9, 1'b1);           cycle();
    check("midrst_uflow_perr", {31'd0, protocol_err}, 32'd1);
    check("midrst_uflow_done", {31'd0, done},         32'd0);

    // ---------------- Pending overflow ----------------
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_aw(4'(i), Other, 8'd0);
      cycle();
    end
    check("ovf_at_max_perr", {31'd0, protocol_err}, 32'd0);
    set_aw(4'd9, Other, 8'd0); cycle();
    check("ovf_perr", {31'd0, protocol_err}, 32'd1);

    // ---------------- Exit AW with len != 0 ----------------
    do_reset();
    set_aw(4'd4, exitAddr, 8'd1); cycle();
    check("len_perr", {31'd0, protocol_err}, 32'd1);
    set_w(64'h10, 1'b0); cycle();
    set_w(64'h11, 1'b1); cycle();
    set_b(4'd4, RespOkay); cycle();
    check("len_done", {31'd0, done}, 32'd1);
    check("len_code", exit_code,     32'd8);

    // ---------------- Second exit AW ignored ----------------
    do_reset();
    set_aw(4'd3, exitAddr, 8'd0); cycle();
    set_aw(4'd6, exitAddr, 8'd0); cycle();
    set_w(64'h6, 1'b1);           cycle();
    set_b(4'd6, RespOkay);        cycle();
    check("second_aw_done_pre", {31'd0, done}, 32'd0);
    set_b(4'd3, RespOkay);        cycle();
    check("second_aw_done", {31'd0, done},         32'd1);
    check("second_aw_code", exit_code,             32'd3);
    check("second_aw_perr", {31'd0, protocol_err}, 32'd0);

    // ---------------- Watchdog ----------------
    do_reset();
`ifdef CULSANS_EXIT_TIMEOUT_EN
    for (int i = 0; i < 99; i++) cycle();
    check("wd_before", {31'd0, timeout}, 32'd0);
    cycle();
    check("wd_at_limit", {31'd0, timeout}, 32'd1);
    cycle();
    check("wd_sticky", {31'd0, timeout}, 32'd1);
`else
    for (int i = 0; i < 120; i++) cycle();
    check("wd_disabled", {31'd0, timeout}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/culsans_exit_monitor.md
CULSANS_EXIT_MONITOR -- requirements
Module: culsans_exit_monitor

Interface
REQ-001 SHALL have parameter ExitAddr, default culsans_pkg::exitAddr, the 64-bit address whose write ends simulation.
REQ-002 SHALL have parameter MaxPending, default 8, the maximum number of AW bursts still awaiting W last.
REQ-003 SHALL have parameter TimeoutCycles, default 32'd10_000_000, the watchdog limit in cycles.
REQ-004 SHALL have type parameters req_t and resp_t, defaults culsans_pkg::req_slv_t and culsans_pkg::resp_slv_t.
REQ-005 SHALL have ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; synchronous, active-high.
- req_i  in  req_t  monitored request; passive, never driven.
- resp_i  in  resp_t  monitored response; passive.
- done_o  out  1  sticky; exit write completed.
- exit_code_o  out  32  {1'b0, captured wdata[31:1]}.
- pass_o  out  1  done_o and exit_code_o==0.
- resp_err_o  out  1  sticky; exit B resp != OKAY.
- protocol_err_o  out  1  sticky; monitor protocol violation.
- timeout_o  out  1  sticky; watchdog expired.

Function
REQ-006 SHALL define a handshake as valid&ready sampled at the rising edge of clk_i.
REQ-007 SHALL keep pend, an unsigned count of clog2(MaxPending+1) bits: +1 per AW handshake, -1 per W handshake with last; simultaneous events give a net 0.
REQ-008 SHALL set protocol_err_o when pend would exceed MaxPending (pend then saturates) or go below 0 (pend then holds 0).
REQ-009 SHALL use FSM states IDLE, WAIT_W, WAIT_B, DONE.
REQ-010 IDLE->WAIT_W on an AW handshake with aw.addr==ExitAddr: capture aw.id; set skip = pend - (W-last handshake this cycle ? 1 : 0).
REQ-011 SHALL set protocol_err_o if that exit AW has len != 0; tracking continues and only the first beat is captured.
REQ-012 In WAIT_W, each W-last handshake SHALL decrement skip while skip>0; the first W handshake with skip==0 SHALL capture w.data[31:0], ->WAIT_B.
REQ-013 If skip reaches 0 on a W-last handshake, that beat belongs to an earlier burst and SHALL NOT be captured.
REQ-014 In WAIT_B, a B handshake with b.id==captured id SHALL ->DONE, set done_o, and set resp_err_o if b.resp != OKAY; B handshakes with other ids SHALL be ignored.
REQ-015 Exit AWs seen outside IDLE SHALL be ignored; only the first exit write is tracked.
REQ-016 done_o and exit_code_o SHALL update one cycle after the completing B handshake and hold until reset.
REQ-017 Read channels SHALL be ignored.

Reset
REQ-018 rst_i high at a clock edge SHALL force IDLE, clear pend, skip, captured id and data, and drive all outputs to 0 at that edge, including mid-transaction.

Configuration
REQ-019 With CULSANS_EXIT_TIMEOUT_EN defined: a 32-bit counter SHALL increment each cycle while not DONE; timeout_o SHALL set when the count reaches TimeoutCycles; the counter freezes after timeout or DONE.
REQ-020 Without CULSANS_EXIT_TIMEOUT_EN: timeout_o SHALL be tied 0, no counter SHALL exist, and TimeoutCycles SHALL be unused.

Structure
REQ-021 exitAddr SHALL stay in culsans_pkg; the FSM state enum exit_mon_state_t SHALL be added to culsans_pkg.
REQ-022 SHALL be a single module with no sub-modules.

Verification
REQ-023 AW(id=3, addr=ExitAddr, len=0), W(data=0x1, last), B(id=3, OKAY) -> done_o=1, exit_code_o=0, pass_o=1, one cycle after B.
REQ-024 Two prior AWs (len=1) with W pending, then exit AW, then 4 W beats, then exit W data=0xB -> captured data is the fifth beat, exit_code_o=5, pass_o=0.
REQ-025 B(id=2, OKAY) then B(id=3, SLVERR) in WAIT_B with captured id 3 -> done_o only after the id=3 B, resp_err_o=1.
REQ-026 AW handshake and W-last handshake in the same cycle with pend=1 -> pend stays 1; exit AW gets skip=0; the next W beat is captured.
REQ-027 rst_i asserted in WAIT_B, then B(id=3) -> remains IDLE, done_o=0; W handshake with pend=0 -> protocol_err_o=1.
REQ-028 CULSANS_EXIT_TIMEOUT_EN defined, TimeoutCycles=100, no exit write -> timeout_o=1 at cycle 100; macro undefined -> timeout_o stays 0.
